// File: rtl/warp_scoreboard_if.sv
// ---------------------------------------------------------------------------
// warp_scoreboard_if
//   Bundles the signals between warp scheduler/decode and the scoreboard:
//   the issue handshake (one instruction per cycle) and the long-latency
//   writeback notification.
//
//   issue_valid      decode presents an instruction
//   issue_warp_id    warp of the presented instruction
//   issue_rs1/2/3    source registers (0 = unused / zero register)
//   issue_rd         destination register
//   issue_reg_write  instruction writes issue_rd
//   issue_long_lat   result returns out-of-band through wb_*
//   issue_ready      instruction may issue this cycle (scoreboard output)
//   wb_valid         a long-latency result is written back this cycle
//   wb_warp_id       warp of the writeback
//   wb_rd            register being written back
//
//   master: decode/writeback side.  slave: the scoreboard.
// ---------------------------------------------------------------------------
interface warp_scoreboard_if #(
  parameter int WARP_ID_WIDTH  = 2,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      issue_valid;
  logic [WARP_ID_WIDTH-1:0]  issue_warp_id;
  logic [REG_ADDR_WIDTH-1:0] issue_rs1;
  logic [REG_ADDR_WIDTH-1:0] issue_rs2;
  logic [REG_ADDR_WIDTH-1:0] issue_rs3;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic                      issue_reg_write;
  logic                      issue_long_lat;
  logic                      issue_ready;
  logic                      wb_valid;
  logic [WARP_ID_WIDTH-1:0]  wb_warp_id;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;

  modport master (
    output issue_valid, issue_warp_id, issue_rs1, issue_rs2, issue_rs3,
           issue_rd, issue_reg_write, issue_long_lat,
           wb_valid, wb_warp_id, wb_rd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_warp_id, issue_rs1, issue_rs2, issue_rs3,
           issue_rd, issue_reg_write, issue_long_lat,
           wb_valid, wb_warp_id, wb_rd,
    output issue_ready
  );
endinterface

// File: rtl/warp_scoreboard.sv
// ---------------------------------------------------------------------------
// warp_scoreboard
//   Per-warp register scoreboard for long-latency producers (global loads,
//   SFU ops). Holds one pending bit per (warp, register) and a per-warp
//   outstanding-write counter, and drops issue_ready on RAW/WAW hazards
//   against in-flight long-latency writes or when the warp is at its
//   outstanding-write limit. Short-latency producers are left to forwarding.
//
//   clk                 single clock, rising edge
//   rst_n               synchronous active-low reset
//   sb_if (slave)       issue handshake + writeback notification
//   warp_idle_o         bit w set when warp w has no outstanding writes
//   stall_count_o       saturating count of cycles with valid && !ready
//   err_spurious_wb_o   sticky: writeback arrived for a non-pending entry
//
//   Warp IDs are assumed to be below NUM_WARPS.
// ---------------------------------------------------------------------------
module warp_scoreboard #(
  parameter int WARPS_PER_CORE = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_WARPS      = WARPS_PER_CORE,
  parameter int NUM_REGS       = 2**REG_ADDR_WIDTH,
  parameter int MAX_PENDING    = 8,
  parameter int WARP_ID_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  warp_scoreboard_if.slave     sb_if,
  output logic [NUM_WARPS-1:0] warp_idle_o,
  output logic [31:0]          stall_count_o,
  output logic                 err_spurious_wb_o
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  typedef logic [CNT_W-1:0]          cnt_t;
  typedef logic [WARP_ID_WIDTH-1:0]  wid_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

  // Local copies of the interface inputs keep the expressions readable.
  logic issue_valid, issue_reg_write, issue_long_lat, wb_valid;
  wid_t issue_warp_id, wb_warp_id;
  reg_t issue_rs1, issue_rs2, issue_rs3, issue_rd, wb_rd;

  assign issue_valid     = sb_if.issue_valid;
  assign issue_warp_id   = sb_if.issue_warp_id;
  assign issue_rs1       = sb_if.issue_rs1;
  assign issue_rs2       = sb_if.issue_rs2;
  assign issue_rs3       = sb_if.issue_rs3;
  assign issue_rd        = sb_if.issue_rd;
  assign issue_reg_write = sb_if.issue_reg_write;
  assign issue_long_lat  = sb_if.issue_long_lat;
  assign wb_valid        = sb_if.wb_valid;
  assign wb_warp_id      = sb_if.wb_warp_id;
  assign wb_rd           = sb_if.wb_rd;

  logic [NUM_REGS-1:0] pend_q [NUM_WARPS];
  logic [NUM_REGS-1:0] pend_d [NUM_WARPS];
  cnt_t                cnt_q  [NUM_WARPS];
  cnt_t                cnt_d  [NUM_WARPS];
  logic [31:0]         stall_q, stall_d;
  logic                err_q, err_d;

  logic wb_hit;      // writeback retires a genuinely pending entry
  logic tracked;     // presented instruction would be tracked if issued
  logic raw_hz, waw_hz, full_hz;
  logic issue_ready;
  logic set_pend;
  cnt_t cnt_eff;

  // Pending as seen this cycle: a same-cycle writeback already resolves it,
  // mirroring the WB bypass into operand fetch.
  function automatic logic p_eff(input wid_t w, input reg_t r);
    return pend_q[w][r] && !(wb_valid && wb_warp_id == w && wb_rd == r);
  endfunction

  // Bit 0 of every pend row is held at 0, so a writeback to r0 never hits.
  assign wb_hit  = wb_valid && pend_q[wb_warp_id][wb_rd];
  assign tracked = issue_long_lat && issue_reg_write && (issue_rd != '0);

  assign raw_hz = ((issue_rs1 != '0) && p_eff(issue_warp_id, issue_rs1)) ||
                  ((issue_rs2 != '0) && p_eff(issue_warp_id, issue_rs2)) ||
                  ((issue_rs3 != '0) && p_eff(issue_warp_id, issue_rs3));

  assign waw_hz = issue_reg_write && (issue_rd != '0) &&
                  p_eff(issue_warp_id, issue_rd);

  // A retiring writeback frees a slot in the same cycle it clears the bit.
  assign cnt_eff = cnt_q[issue_warp_id] -
                   cnt_t'(wb_hit && (wb_warp_id == issue_warp_id));
  assign full_hz = tracked && (cnt_eff == cnt_t'(MAX_PENDING));

  assign issue_ready       = !(raw_hz || waw_hz || full_hz);
  assign sb_if.issue_ready = issue_ready;
  assign set_pend          = issue_valid && issue_ready && tracked;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    err_d   = err_q;

    for (int w = 0; w < NUM_WARPS; w++) begin
      cnt_d[w] = cnt_q[w]
               + cnt_t'(set_pend && (issue_warp_id == wid_t'(w)))
               - cnt_t'(wb_hit   && (wb_warp_id    == wid_t'(w)));
    end

    // Clear before set: a same-entry set+clear leaves the bit at 1.
    if (wb_hit)   pend_d[wb_warp_id][wb_rd]       = 1'b0;
    if (set_pend) pend_d[issue_warp_id][issue_rd] = 1'b1;
    for (int w = 0; w < NUM_WARPS; w++) pend_d[w][0] = 1'b0;

    if (issue_valid && !issue_ready && (stall_q != '1))
      stall_d = stall_q + 32'd1;

    if (wb_valid && !wb_hit) err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the pend array is flop-based and architecturally visible, so it
      // is reset in full; leaving it unreset would create phantom hazards.
      for (int w = 0; w < NUM_WARPS; w++) begin
        pend_q[w] <= '0;
        cnt_q[w]  <= '0;
      end
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    warp_idle_o = '0;
    for (int w = 0; w < NUM_WARPS; w++) warp_idle_o[w] = (cnt_q[w] == '0);
  end

  assign stall_count_o     = stall_q;
  assign err_spurious_wb_o = err_q;

endmodule

// File: doc/warp_scoreboard.md
# warp_scoreboard

Per-warp register scoreboard that gates instruction issue from the decode stage for long-latency results (global loads, SFU ops), which the EX/MEM/WB forwarding bypass cannot supply. It sits between the warp scheduler/decode and operand fetch. It tracks one pending bit per (warp, register) and a per-warp outstanding-write counter, and deasserts `issue_ready` on RAW or WAW hazards against in-flight long-latency writes. Short-latency producers are not tracked here; the forwarding unit resolves them.

## Interface
- `NUM_WARPS`, default `WARPS_PER_CORE`: warps tracked.
- `NUM_REGS`, default `2**REG_ADDR_WIDTH`: architectural registers per warp. Register 0 is never tracked.
- `MAX_PENDING`, default 8: per-warp outstanding long-latency write limit, ≥1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `issue_valid` in 1: decode presents an instruction.
- `issue_warp_id` in `WARP_ID_WIDTH`: warp of the presented instruction.
- `issue_rs1`, `issue_rs2`, `issue_rs3` in `REG_ADDR_WIDTH` each: source registers.
- `issue_rd` in `REG_ADDR_WIDTH`: destination register.
- `issue_reg_write` in 1: instruction writes `issue_rd`.
- `issue_long_lat` in 1: result returns out-of-band through `wb_*`, not via forwarding.
- `issue_ready` out 1: instruction may issue this cycle. Issue occurs when `issue_valid && issue_ready`.
- `wb_valid` in 1: a long-latency result is written back this cycle.
- `wb_warp_id` in `WARP_ID_WIDTH`: warp of the writeback.
- `wb_rd` in `REG_ADDR_WIDTH`: register being written back.
- `warp_idle` out `NUM_WARPS`: bit w is 1 when warp w has zero outstanding long-latency writes. Used for barrier/exit.
- `stall_count` out 32: saturating count of cycles with `issue_valid && !issue_ready`.
- `err_spurious_wb` out 1: sticky; a writeback arrived for a non-pending entry.

## Operation
- State:
  - `pend[w][r]`: one bit per warp w and register r; `r==0` is hard-wired to 0.
  - `cnt[w]`: per-warp counter, width `$clog2(MAX_PENDING+1)`.
- Effective pending `p_eff[w][r] = pend[w][r] && !(wb_valid && wb_warp_id==w && wb_rd==r)`. A same-cycle writeback clears the hazard, matching the WB bypass.
- `issue_ready` is 0 (stall) if any of the following holds, for warp `w = issue_warp_id`:
  - `p_eff[w][rsN]` for any N in 1..3 with `rsN != 0` (RAW).
  - `issue_reg_write && issue_rd != 0 && p_eff[w][issue_rd]` (WAW).
  - `issue_long_lat && issue_reg_write && issue_rd != 0 && cnt_eff[w] == MAX_PENDING`, where `cnt_eff` is `cnt` minus 1 if a valid writeback to warp w clears a pending bit this cycle.
- `issue_ready` is otherwise 1, and is independent of `issue_valid`.
- Set: an accepted issue with `issue_long_lat && issue_reg_write && issue_rd != 0` sets `pend[w][rd]` and increments `cnt[w]`.
- Long-latency issue with `rd == 0` or without `issue_reg_write`: nothing is tracked.
- Clear: `wb_valid` with `pend[wb_warp_id][wb_rd]==1` clears the bit and decrements `cnt`.
- Spurious writeback: `wb_valid` to a non-pending entry, including `rd==0`, changes no state and sets `err_spurious_wb`.
- Simultaneous set and clear:
  - Same warp/reg: the bit ends at 1 and `cnt` is unchanged. This is legal because the WAW check uses `p_eff`.
  - Different entries: both apply; `cnt` gets the net change.
- `stall_count` increments on every cycle with `issue_valid && !issue_ready` and saturates at `32'hFFFF_FFFF`.

## Timing
- Reset values (`rst_n==0` at a clock edge):
  - All `pend` = 0, all `cnt` = 0.
  - `warp_idle` = all ones, `stall_count` = 0, `err_spurious_wb` = 0.
  - `issue_ready` = 1 for any input once reset state is loaded.
- Reset asserted mid-operation discards all pending state on that edge. `wb_valid` during reset is ignored and does not set the error flag.
- `issue_ready` is combinational from `issue_*`, `wb_*` and registered state in the same cycle, with zero-cycle decision latency.
- A set takes effect from the cycle after acceptance: a dependent instruction presented one cycle later sees the hazard.
- A clear is visible in the same cycle via `p_eff` and is registered on the next edge.
- `warp_idle` and `err_spurious_wb` are registered and reflect the state after each edge.

## Test plan
- Reset, then present warp 2 `rs1=5` with no pending writes → `issue_ready=1`, `warp_idle=all ones`, `stall_count=0`.
- Issue long-lat load warp 1 `rd=7`; next cycle present warp 1 `rs2=7` → `issue_ready=0` and `stall_count` increments each cycle. Same instruction on warp 0 → `issue_ready=1`.
- With `pend[1][7]` set, drive `wb_valid` warp 1 `rd=7` in the same cycle as warp 1 `rs1=7` → `issue_ready=1`. Next cycle `warp_idle[1]=1`.
- Same cycle as the above clear, issue a long-lat write to warp 1 `rd=7` → accepted, `pend[1][7]` stays 1, `cnt[1]` stays 1.
- Issue `MAX_PENDING`=8 long-lat writes to warp 3 `rd=1..8`, then a 9th to `rd=9` → stalled until any of `rd=1..8` writes back, then accepted in that same cycle.
- `wb_valid` warp 0 `rd=4` while nothing is pending → `err_spurious_wb=1` next cycle, `warp_idle[0]` stays 1. Assert `rst_n=0` for one cycle → flag returns to 0.
